kfps2kb_command_scheduler: RTL and testbench
============================================

Name: kfps2kb_command_scheduler

Overview:
- Sequences host-to-keyboard commands through the PS/2 send datapath: pulses its send request, tracks its busy flag, waits for the keyboard ACK (0xFA), and retries on RESEND (0xFE) or timeout.
- Arbitrates between two requesters: a single-byte host command port and an LED-update port, which issues the two-byte sequence 0xED, {5'b0, leds}.
- Received bytes that are not consumed as ACK/RESEND pass through to the scancode consumer.
- Sits between the keyboard controller glue, the PS/2 send block and the PS/2 receive block.

Parameters:
- ACK_TIMEOUT, 20'd600000: clock cycles allowed in WAIT_ACK before a retry.
- START_TIMEOUT, 16'd1000: clock cycles allowed for tx_busy to rise after ISSUE.
- MAX_RETRY, 2'd3: re-sends allowed per byte before the transaction fails.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- host_cmd_req  in  1  level request; held until host_cmd_ack
- host_cmd_data  in  8  command byte; stable while req is high
- host_cmd_ack  out  1  one-cycle pulse when the host transaction ends
- cmd_error  out  1  one-cycle pulse, coincident with the ack/LED completion, on failure
- led_update  in  1  one-cycle pulse; captures led_state
- led_state  in  3  {caps, num, scroll}
- tx_send_request  out  1  to the send block (rising-edge triggered)
- tx_send_data  out  8  byte to the send block
- tx_busy  in  1  send block sending_data_flag
- rx_valid  in  1  one-cycle strobe from the receive block
- rx_data  in  8  received byte
- scancode_valid  out  1  one-cycle strobe of a forwarded byte
- scancode  out  8  forwarded byte
- busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: one clock, clock. Reset is reset_n, asynchronous and active-low.
- Reset values: all outputs 0; tx_send_data 8'h00; led_pending 0; counters 0; state IDLE. Reset mid-transaction abandons it with no ack pulse.
- LED capture: led_update sets led_pending and latches led_state into led_reg.
  - Latest value wins while pending.
  - led_update during an LED transaction re-sets led_pending, so another transaction follows.
- States: IDLE, ISSUE, WAIT_START, WAIT_TX, WAIT_ACK, DONE.
- IDLE arbitration, fixed priority, host first:
  - If host_cmd_req: owner=HOST, byte_idx=0, tx_send_data<=host_cmd_data.
  - Else if led_pending: owner=LED, clear led_pending, byte_idx=0, tx_send_data<=8'hED.
  - Both paths go to ISSUE. No arbitration occurs outside IDLE.
- ISSUE: tx_send_request=1 for exactly this one cycle, then WAIT_START.
  - tx_send_data is stable from ISSUE through the WAIT_TX exit.
- WAIT_START: tx_busy=1 -> WAIT_TX. START_TIMEOUT cycles elapse -> retry path.
- WAIT_TX: tx_busy=0 -> WAIT_ACK; the timeout counter clears on entry.
- WAIT_ACK:
  - rx_valid with 8'hFA: if owner=LED and byte_idx=0, set byte_idx=1, tx_send_data<={5'b0,led_reg}, retry_cnt=0, go to ISSUE. Otherwise go to DONE.
  - rx_valid with 8'hFE: retry path.
  - rx_valid with any other byte: forward it and stay; the timeout keeps running.
  - Counter reaches ACK_TIMEOUT: retry path.
- Retry path:
  - retry_cnt<MAX_RETRY: increment it and go to ISSUE with the same byte.
  - Otherwise: go to DONE with the fail flag set.
  - retry_cnt clears when each new byte starts.
- DONE (one cycle), then IDLE:
  - owner=HOST: host_cmd_ack=1.
  - cmd_error=1 if failed, for either owner.
  - The requester drops host_cmd_req on the edge where it samples the ack, so IDLE never re-accepts the same command.
- Forwarding: bytes not consumed in WAIT_ACK go out as scancode/scancode_valid with 1-cycle registered latency, in every state.
  - 0xFA/0xFE arriving outside WAIT_ACK are forwarded.
- Simultaneous events:
  - rx_valid on the same cycle the timeout expires: the byte has priority.
  - led_update in the IDLE cycle where the host wins stays pending.
- Outputs are registered. tx_send_request is never high for two consecutive cycles.

Test Plan:
- Host req 0xFF; model raises tx_busy 2 cycles after request for 50 cycles, then rx 0xFA -> exactly one tx_send_request pulse with data 0xFF, host_cmd_ack pulse, cmd_error=0, busy=0 next cycle.
- led_update with led_state=3'b101; ACK both bytes -> tx bytes 0xED then 0x05, no host_cmd_ack, no scancode_valid.
- Host req 0xF4; rx 0xFE three times, then 0xFA -> four identical sends of 0xF4, then ack without error. With four 0xFE -> ack plus cmd_error, 4 sends total.
- rx 0x1C during WAIT_ACK, then 0xFA -> scancode=0x1C forwarded once; 0xFA not forwarded. rx 0xFA in IDLE -> forwarded.
- host_cmd_req and led_update in the same cycle -> host byte is sent first, then the 0xED/LED sequence. tx_busy never rising -> retry after START_TIMEOUT cycles.
- reset_n low during WAIT_TX -> all outputs are 0 immediately (asynchronous); after release, IDLE with no ack pulse.

Source files
------------

// File: rtl/kfps2kb_command_scheduler_if.sv
// Signal bundle between the command scheduler and its surroundings: host command
// port, LED-update port, PS/2 send/receive datapath and the scancode consumer.
interface kfps2kb_command_scheduler_if;
    logic       host_cmd_req;
    logic [7:0] host_cmd_data;
    logic       host_cmd_ack;
    logic       cmd_error;
    logic       led_update;
    logic [2:0] led_state;
    logic       tx_send_request;
    logic [7:0] tx_send_data;
    logic       tx_busy;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       scancode_valid;
    logic [7:0] scancode;
    logic       busy;

    // Environment side: requesters, send/receive blocks and scancode consumer.
    modport master (
        output host_cmd_req, host_cmd_data, led_update, led_state, tx_busy, rx_valid, rx_data,
        input  host_cmd_ack, cmd_error, tx_send_request, tx_send_data, scancode_valid, scancode, busy
    );

    // Scheduler side.
    modport slave (
        input  host_cmd_req, host_cmd_data, led_update, led_state, tx_busy, rx_valid, rx_data,
        output host_cmd_ack, cmd_error, tx_send_request, tx_send_data, scancode_valid, scancode, busy
    );
endinterface

// File: rtl/kfps2kb_command_scheduler.sv
// Host-to-keyboard command scheduler: arbitrates host and LED requests, drives the
// PS/2 send block, waits for ACK and retries on RESEND or timeout.
module kfps2kb_command_scheduler #(
    parameter logic [19:0] ACK_TIMEOUT   = 20'd600000,
    parameter logic [15:0] START_TIMEOUT = 16'd1000,
    parameter logic [1:0]  MAX_RETRY     = 2'd3
) (
    input  logic clock,
    input  logic reset_n,
    kfps2kb_command_scheduler_if.slave bus
);
    localparam logic [7:0] KB_ACK    = 8'hFA;
    localparam logic [7:0] KB_RESEND = 8'hFE;
    localparam logic [7:0] KB_SETLED = 8'hED;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_TX, WAIT_ACK, DONE} state_e;
    typedef enum logic {OWNER_HOST, OWNER_LED} owner_e;

    state_e      state_q;
    owner_e      owner_q;
    logic        byte_idx_q;
    logic [1:0]  retry_cnt_q;
    logic [19:0] timer_q;
    logic        led_pending_q;
    logic [2:0]  led_reg_q;
    logic        tx_send_request_q;
    logic [7:0]  tx_send_data_q;
    logic        host_cmd_ack_q;
    logic        cmd_error_q;
    logic        scancode_valid_q;
    logic [7:0]  scancode_q;

    logic rx_ack, rx_resend, rx_consumed, start_expired, ack_expired, retry_now;

    assign rx_ack        = (state_q == WAIT_ACK) && bus.rx_valid && (bus.rx_data == KB_ACK);
    assign rx_resend     = (state_q == WAIT_ACK) && bus.rx_valid && (bus.rx_data == KB_RESEND);
    assign rx_consumed   = rx_ack || rx_resend;
    assign start_expired = timer_q >= ({4'd0, START_TIMEOUT} - 20'd1);
    assign ack_expired   = timer_q >= (ACK_TIMEOUT - 20'd1);
    // Any received byte outranks a timeout expiring in the same cycle.
    assign retry_now     = ((state_q == WAIT_START) && !bus.tx_busy && start_expired) ||
                           rx_resend ||
                           ((state_q == WAIT_ACK) && !bus.rx_valid && ack_expired);

    // NOTE: all state uses non-blocking assignments; a later assignment in this block
    // deliberately overrides an earlier one (retry path over the per-state step,
    // led_update over the IDLE clear of led_pending).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            owner_q           <= OWNER_HOST;
            byte_idx_q        <= 1'b0;
            retry_cnt_q       <= 2'd0;
            timer_q           <= 20'd0;
            led_pending_q     <= 1'b0;
            led_reg_q         <= 3'd0;
            tx_send_request_q <= 1'b0;
            tx_send_data_q    <= 8'h00;
            host_cmd_ack_q    <= 1'b0;
            cmd_error_q       <= 1'b0;
            scancode_valid_q  <= 1'b0;
            scancode_q        <= 8'h00;
        end else begin
            tx_send_request_q <= 1'b0;
            host_cmd_ack_q    <= 1'b0;
            cmd_error_q       <= 1'b0;
            scancode_valid_q  <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (bus.host_cmd_req) begin
                        owner_q           <= OWNER_HOST;
                        byte_idx_q        <= 1'b0;
                        retry_cnt_q       <= 2'd0;
                        tx_send_data_q    <= bus.host_cmd_data;
                        tx_send_request_q <= 1'b1;
                        state_q           <= ISSUE;
                    end else if (led_pending_q) begin
                        owner_q           <= OWNER_LED;
                        led_pending_q     <= 1'b0;
                        byte_idx_q        <= 1'b0;
                        retry_cnt_q       <= 2'd0;
                        tx_send_data_q    <= KB_SETLED;
                        tx_send_request_q <= 1'b1;
                        state_q           <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_q <= 20'd0;
                    state_q <= WAIT_START;
                end
                WAIT_START: begin
                    if (bus.tx_busy) state_q <= WAIT_TX;
                    else             timer_q <= timer_q + 20'd1;
                end
                WAIT_TX: begin
                    if (!bus.tx_busy) begin
                        timer_q <= 20'd0;
                        state_q <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (rx_ack) begin
                        if (owner_q == OWNER_LED && !byte_idx_q) begin
                            byte_idx_q        <= 1'b1;
                            tx_send_data_q    <= {5'b0, led_reg_q};
                            retry_cnt_q       <= 2'd0;
                            tx_send_request_q <= 1'b1;
                            state_q           <= ISSUE;
                        end else begin
                            host_cmd_ack_q <= (owner_q == OWNER_HOST);
                            state_q        <= DONE;
                        end
                    end else begin
                        timer_q <= timer_q + 20'd1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (retry_now) begin
                if (retry_cnt_q < MAX_RETRY) begin
                    retry_cnt_q       <= retry_cnt_q + 2'd1;
                    tx_send_request_q <= 1'b1;
                    state_q           <= ISSUE;
                end else begin
                    host_cmd_ack_q <= (owner_q == OWNER_HOST);
                    cmd_error_q    <= 1'b1;
                    state_q        <= DONE;
                end
            end

            if (bus.led_update) begin
                led_pending_q <= 1'b1;
                led_reg_q     <= bus.led_state;
            end

            if (bus.rx_valid && !rx_consumed) begin
                scancode_valid_q <= 1'b1;
                scancode_q       <= bus.rx_data;
            end
        end
    end

    assign bus.tx_send_request = tx_send_request_q;
    assign bus.tx_send_data    = tx_send_data_q;
    assign bus.host_cmd_ack    = host_cmd_ack_q;
    assign bus.cmd_error       = cmd_error_q;
    assign bus.scancode_valid  = scancode_valid_q;
    assign bus.scancode        = scancode_q;
    assign bus.busy            = (state_q != IDLE);
endmodule

// File: tb/tb_kfps2kb_command_scheduler.sv
// Directed bench for the command scheduler: a behavioural send block, a table of
// host transactions and hand-written LED, forwarding, arbitration and reset sequences.
module tb_kfps2kb_command_scheduler;
    localparam int ST = 20;
    localparam int AT = 200;
    localparam int WAIT_BOUND = 5000;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    kfps2kb_command_scheduler_if bus();

    kfps2kb_command_scheduler #(
        .ACK_TIMEOUT  (20'(AT)),
        .START_TIMEOUT(16'(ST)),
        .MAX_RETRY    (2'd3)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    always @(posedge clock) cycle++;

    logic [7:0] sent_q[$];
    int         send_time_q[$];
    logic [7:0] sc_q[$];
    int         ack_cnt = 0;
    int         err_cnt = 0;
    int         dbl_cnt = 0;
    logic       prev_req = 1'b0;

    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.tx_send_request) begin
                sent_q.push_back(bus.tx_send_data);
                send_time_q.push_back(cycle);
                if (prev_req) dbl_cnt++;
            end
            if (bus.host_cmd_ack)   ack_cnt++;
            if (bus.cmd_error)      err_cnt++;
            if (bus.scancode_valid) sc_q.push_back(bus.scancode);
        end
        prev_req = bus.tx_send_request;
    end

    // Send block model: tx_busy rises 2 cycles after the request, for busy_len cycles.
    bit model_en = 1'b1;
    int busy_len = 5;
    int tx_done_cnt = 0;
    int tx_done_used = 0;
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (model_en && reset_n && bus.tx_send_request) begin
                @(posedge clock);
                @(posedge clock);
                #1 bus.tx_busy = 1'b1;
                repeat (busy_len) @(posedge clock);
                #1 bus.tx_busy = 1'b0;
                tx_done_cnt++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive_rx(input logic [7:0] b);
        @(posedge clock);
        #1 bus.rx_valid = 1'b1;
        bus.rx_data = b;
        @(posedge clock);
        #1 bus.rx_valid = 1'b0;
    endtask

    // Wait for the next completed send, then answer once the scheduler is in WAIT_ACK.
    task automatic respond(input logic [7:0] b);
        int n = 0;
        while (tx_done_cnt <= tx_done_used && n < WAIT_BOUND) begin
            @(posedge clock);
            n++;
        end
        check("respond_wait_tx_done", 32'(n < WAIT_BOUND), 32'd1);
        tx_done_used++;
        drive_rx(b);
    endtask

    task automatic wait_ack_drop();
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < WAIT_BOUND) begin
            @(negedge clock);
            seen = bus.host_cmd_ack;
            n++;
        end
        check("host_ack_seen", 32'(seen), 32'd1);
        @(posedge clock);
        #1 bus.host_cmd_req = 1'b0;
        @(negedge clock);
        check("busy_low_after_ack", 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while (bus.busy && n < WAIT_BOUND) begin
            @(negedge clock);
            n++;
        end
        check("idle_reached", 32'(n < WAIT_BOUND), 32'd1);
    endtask

    function automatic logic [31:0] out_vector();
        return {8'd0, bus.tx_send_request, bus.host_cmd_ack, bus.cmd_error, bus.scancode_valid,
                bus.busy, bus.tx_send_data, bus.scancode, 3'd0};
    endfunction

    typedef struct {
        logic [7:0] cmd;
        int         n_resend;
        bit         no_reply;
        int         blen;
        int         exp_sends;
        bit         exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int a0, e0, bad;
        logic [31:0] got;

        vecs[0] = '{cmd: 8'hFF, n_resend: 0, no_reply: 1'b0, blen: 50, exp_sends: 1, exp_err: 1'b0};
        vecs[1] = '{cmd: 8'hF4, n_resend: 3, no_reply: 1'b0, blen: 5,  exp_sends: 4, exp_err: 1'b0};
        vecs[2] = '{cmd: 8'hF4, n_resend: 4, no_reply: 1'b0, blen: 5,  exp_sends: 4, exp_err: 1'b1};
        vecs[3] = '{cmd: 8'hEE, n_resend: 1, no_reply: 1'b0, blen: 5,  exp_sends: 2, exp_err: 1'b0};
        vecs[4] = '{cmd: 8'hF2, n_resend: 0, no_reply: 1'b1, blen: 5,  exp_sends: 4, exp_err: 1'b1};

        bus.host_cmd_req  = 1'b0;
        bus.host_cmd_data = 8'h00;
        bus.led_update    = 1'b0;
        bus.led_state     = 3'd0;
        bus.rx_valid      = 1'b0;
        bus.rx_data       = 8'h00;

        #2 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", out_vector(), 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clock);

        // Table of host transactions with RESEND counts and timeouts.
        for (int i = 0; i < 5; i++) begin
            sent_q.delete();
            sc_q.delete();
            a0 = ack_cnt;
            e0 = err_cnt;
            busy_len = vecs[i].blen;
            @(posedge clock);
            #1 bus.host_cmd_req = 1'b1;
            bus.host_cmd_data = vecs[i].cmd;
            if (!vecs[i].no_reply) begin
                for (int k = 0; k < vecs[i].n_resend; k++) respond(8'hFE);
                if (!vecs[i].exp_err) respond(8'hFA);
            end
            wait_ack_drop();
            repeat (2) @(posedge clock);
            tx_done_used = tx_done_cnt;
            bad = 0;
            foreach (sent_q[j]) if (sent_q[j] !== vecs[i].cmd) bad++;
            check($sformatf("v%0d_sends", i), 32'(sent_q.size()), 32'(vecs[i].exp_sends));
            check($sformatf("v%0d_send_data", i), 32'(bad), 32'd0);
            check($sformatf("v%0d_acks", i), 32'(ack_cnt - a0), 32'd1);
            check($sformatf("v%0d_error", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_no_scancode", i), 32'(sc_q.size()), 32'd0);
        end
        busy_len = 5;

        // LED update: 0xED then {5'b0, leds}, no host ack.
        sent_q.delete();
        sc_q.delete();
        a0 = ack_cnt;
        e0 = err_cnt;
        @(posedge clock);
        #1 bus.led_update = 1'b1;
        bus.led_state = 3'b101;
        @(posedge clock);
        #1 bus.led_update = 1'b0;
        respond(8'hFA);
        respond(8'hFA);
        wait_idle();
        got = (sent_q.size() >= 2) ? {16'd0, sent_q[0], sent_q[1]} : 32'hFFFF_FFFF;
        check("led_sends", 32'(sent_q.size()), 32'd2);
        check("led_bytes", got, 32'h0000_ED05);
        check("led_no_ack", 32'(ack_cnt - a0), 32'd0);
        check("led_no_error", 32'(err_cnt - e0), 32'd0);
        check("led_no_scancode", 32'(sc_q.size()), 32'd0);

        // Forwarding: non-ACK byte in WAIT_ACK passes through; ACK in IDLE passes through.
        sent_q.delete();
        sc_q.delete();
        @(posedge clock);
        #1 bus.host_cmd_req = 1'b1;
        bus.host_cmd_data = 8'h55;
        respond(8'h1C);
        drive_rx(8'hFA);
        wait_ack_drop();
        check("fwd_count_in_wait_ack", 32'(sc_q.size()), 32'd1);
        got = (sc_q.size() >= 1) ? 32'(sc_q[0]) : 32'hFFFF_FFFF;
        check("fwd_byte_1c", got, 32'h1C);
        repeat (2) @(posedge clock);
        drive_rx(8'hFA);
        @(negedge clock);
        check("fwd_idle_valid", 32'(bus.scancode_valid), 32'd1);
        check("fwd_idle_byte", 32'(bus.scancode), 32'hFA);
        @(negedge clock);
        check("fwd_idle_single", 32'(bus.scancode_valid), 32'd0);

        // Host request and led_update in the same cycle: host first, then LED sequence.
        sent_q.delete();
        a0 = ack_cnt;
        @(posedge clock);
        #1 bus.host_cmd_req = 1'b1;
        bus.host_cmd_data = 8'hAB;
        bus.led_update = 1'b1;
        bus.led_state = 3'b011;
        @(posedge clock);
        #1 bus.led_update = 1'b0;
        respond(8'hFA);
        wait_ack_drop();
        respond(8'hFA);
        respond(8'hFA);
        wait_idle();
        got = (sent_q.size() >= 3) ? {8'd0, sent_q[0], sent_q[1], sent_q[2]} : 32'hFFFF_FFFF;
        check("arb_sends", 32'(sent_q.size()), 32'd3);
        check("arb_order", got, 32'h00AB_ED03);
        check("arb_acks", 32'(ack_cnt - a0), 32'd1);

        // tx_busy never rises: retry every START_TIMEOUT cycles, then fail.
        model_en = 1'b0;
        sent_q.delete();
        send_time_q.delete();
        e0 = err_cnt;
        @(posedge clock);
        #1 bus.host_cmd_req = 1'b1;
        bus.host_cmd_data = 8'h11;
        wait_ack_drop();
        check("start_to_sends", 32'(sent_q.size()), 32'd4);
        got = (send_time_q.size() >= 2) ? 32'(send_time_q[1] - send_time_q[0]) : 32'hFFFF_FFFF;
        check("start_to_interval", got, 32'(ST + 1));
        check("start_to_error", 32'(err_cnt - e0), 32'd1);
        model_en = 1'b1;
        tx_done_used = tx_done_cnt;

        // Asynchronous reset during WAIT_TX abandons the transaction silently.
        a0 = ack_cnt;
        @(posedge clock);
        #1 bus.host_cmd_req = 1'b1;
        bus.host_cmd_data = 8'h33;
        begin
            int n = 0;
            while (!bus.tx_busy && n < WAIT_BOUND) begin
                @(posedge clock);
                n++;
            end
            check("rst_tx_busy_rose", 32'(bus.tx_busy), 32'd1);
        end
        @(posedge clock);
        @(posedge clock);
        #1;
        check("rst_busy_before", 32'(bus.busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_outputs", out_vector(), 32'd0);
        bus.host_cmd_req = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (20) @(posedge clock);
        tx_done_used = tx_done_cnt;
        @(negedge clock);
        check("rst_no_ack", 32'(ack_cnt - a0), 32'd0);
        check("rst_idle", 32'(bus.busy), 32'd0);

        check("no_back_to_back_request", 32'(dbl_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
